// File: rtl/msg_pkg.sv
// Shared definitions for the OPB message framing blocks (msg_read / msg_write).
package msg_pkg;

  localparam logic [7:0]  MSG_HDR_WR    = 8'h5A;
  localparam logic [7:0]  MSG_HDR_RD    = 8'h5B;
  localparam logic [7:0]  MSG_HDR_RSP   = 8'h5C;
  localparam int unsigned MSG_FRAME_LEN = 10;
  localparam int unsigned MSG_IDX_W     = 4;

  typedef enum logic {
    MSG_WR_IDLE = 1'b0,
    MSG_WR_SEND = 1'b1
  } msg_wr_state_e;

  // Latched read response carried by one frame.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } msg_rsp_t;

  function automatic logic [7:0] msg_tail(input logic [7:0] hdr);
    return ~hdr;
  endfunction

endpackage

// File: rtl/pulse_timeout.sv
// Counts rising edges of a slow pulse while enabled; flags expiry at LIMIT (saturating).
module pulse_timeout #(
  parameter int unsigned LIMIT = 200,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pulse_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic             pulse_q;
  logic             rise_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign rise_c    = pulse_i && !pulse_q;
  assign expired_o = (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && rise_c && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= pulse_i;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/msg_write.sv
// Serialises an OPB read response into a 10-byte frame written into the TX FIFO.
module msg_write
  import msg_pkg::*;
#(
  parameter logic [7:0]  RSP_HEADER     = MSG_HDR_RSP,
  parameter int unsigned TIMEOUT_PULSES = 200,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        PULSE_2KHZ,
  input  logic        RSP_REQ,
  input  logic [31:0] RSP_ADDR,
  input  logic [31:0] RSP_DATA,
  input  logic        TX_FIFO_FULL,
  output logic        TX_FIFO_WR,
  output logic [7:0]  TX_FIFO_DATA,
  output logic        BUSY,
  output logic        error_flag
);

  localparam int unsigned IDX_W = MSG_IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_FRAME_LEN - 1);

  msg_wr_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  msg_rsp_t         shadow_q, shadow_d;
  logic             error_q, error_d;
  logic             accept_c;
  logic             wr_c;
  logic             tail_wr_c;
  logic             expired_c;
  logic [7:0]       byte_c;

  // Write strobe is combinational so a full FIFO blocks the write in the same cycle.
  assign wr_c      = (state_q == MSG_WR_SEND) && !TX_FIFO_FULL;
  assign tail_wr_c = wr_c && (idx_q == LAST_IDX);

  pulse_timeout #(
    .LIMIT (TIMEOUT_PULSES),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk_i     (OPB_CLK),
    .rst_i     (OPB_RST),
    .pulse_i   (PULSE_2KHZ),
    .clear_i   (accept_c),
    .enable_i  (state_q == MSG_WR_SEND),
    .expired_o (expired_c)
  );

  // A request on the tail-write edge chains straight into the next frame.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    error_d  = 1'b0;
    accept_c = 1'b0;
    unique case (state_q)
      MSG_WR_IDLE: accept_c = RSP_REQ;
      MSG_WR_SEND: begin
        if (tail_wr_c) begin
          state_d  = MSG_WR_IDLE;
          accept_c = RSP_REQ;
        end else begin
          error_d = RSP_REQ;
          if (wr_c) idx_d = idx_q + IDX_W'(1);
          if (expired_c) begin
            state_d = MSG_WR_IDLE;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = MSG_WR_IDLE;
    endcase
    if (accept_c) begin
      state_d  = MSG_WR_SEND;
      idx_d    = '0;
      shadow_d = '{addr: RSP_ADDR, data: RSP_DATA};
    end
  end

  // Byte select; unreachable indices decode to the tail.
  always_comb begin
    byte_c = 8'h00;
    if (state_q == MSG_WR_SEND) begin
      case (idx_q)
        4'd0:    byte_c = RSP_HEADER;
        4'd1:    byte_c = shadow_q.addr[31:24];
        4'd2:    byte_c = shadow_q.addr[23:16];
        4'd3:    byte_c = shadow_q.addr[15:8];
        4'd4:    byte_c = shadow_q.addr[7:0];
        4'd5:    byte_c = shadow_q.data[31:24];
        4'd6:    byte_c = shadow_q.data[23:16];
        4'd7:    byte_c = shadow_q.data[15:8];
        4'd8:    byte_c = shadow_q.data[7:0];
        default: byte_c = msg_tail(RSP_HEADER);
      endcase
    end
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state_q  <= MSG_WR_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      error_q  <= error_d;
    end
  end

  assign TX_FIFO_WR   = wr_c;
  assign TX_FIFO_DATA = byte_c;
  assign BUSY         = (state_q == MSG_WR_SEND);
  assign error_flag   = error_q;

endmodule

// File: tb/tb_msg_write.sv
// Directed bench for msg_write: frame content, FULL stalls, overrun, chaining and timeout abort.
module tb_msg_write;

  logic        OPB_CLK;
  logic        OPB_RST;
  logic        PULSE_2KHZ;
  logic        RSP_REQ;
  logic [31:0] RSP_ADDR;
  logic [31:0] RSP_DATA;
  logic        TX_FIFO_FULL;
  logic        TX_FIFO_WR;
  logic [7:0]  TX_FIFO_DATA;
  logic        BUSY;
  logic        error_flag;

  int   n_tot    = 0;
  int   n_pass   = 0;
  int   rise_cnt = 0;
  logic pulse_prev = 1'b0;
  int   ph       = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [31:0]  full_mask;   // bit k: FULL high in frame cycle k
    int           req2_k;      // frame cycle of a second request (0 = none)
    logic [31:0]  addr2;
    logic [31:0]  data2;
    int           exp_nwr;
    logic [159:0] exp_bytes;   // right-aligned byte stream
    int           exp_busy;
    int           exp_err_k;   // frame cycle of error pulse (0 = none)
  } vec_t;

  vec_t vecs[6];

  msg_write dut (
    .OPB_CLK      (OPB_CLK),
    .OPB_RST      (OPB_RST),
    .PULSE_2KHZ   (PULSE_2KHZ),
    .RSP_REQ      (RSP_REQ),
    .RSP_ADDR     (RSP_ADDR),
    .RSP_DATA     (RSP_DATA),
    .TX_FIFO_FULL (TX_FIFO_FULL),
    .TX_FIFO_WR   (TX_FIFO_WR),
    .TX_FIFO_DATA (TX_FIFO_DATA),
    .BUSY         (BUSY),
    .error_flag   (error_flag)
  );

  initial begin
    OPB_CLK = 1'b0;
    forever #5 OPB_CLK = ~OPB_CLK;
  end

  // Pulse with a 5-cycle (50 ns) period: high 2 cycles, low 3.
  initial begin
    PULSE_2KHZ = 1'b0;
    forever begin
      @(posedge OPB_CLK);
      #1;
      ph = (ph == 4) ? 0 : ph + 1;
      PULSE_2KHZ = (ph < 2);
    end
  end

  // Reference count of pulse rising edges seen while a frame is in progress.
  initial begin
    forever begin
      @(negedge OPB_CLK);
      if (BUSY && PULSE_2KHZ && !pulse_prev) rise_cnt++;
      pulse_prev = PULSE_2KHZ;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_frame(input vec_t v, input int vi);
    logic [159:0] got;
    int nwr, busy, errs, first_err, badwr, k;
    bit done;
    got = '0; nwr = 0; busy = 0; errs = 0; first_err = 0; badwr = 0; done = 1'b0;
    @(negedge OPB_CLK);
    RSP_REQ = 1'b1; RSP_ADDR = v.addr; RSP_DATA = v.data;
    @(posedge OPB_CLK);
    #1;
    RSP_REQ = 1'b0; RSP_ADDR = 32'h5555_5555; RSP_DATA = 32'h5555_5555;
    k = 1;
    while (!done && k < 100) begin
      TX_FIFO_FULL = (k < 32) && v.full_mask[k[4:0]];
      if (k == v.req2_k) begin
        RSP_REQ = 1'b1; RSP_ADDR = v.addr2; RSP_DATA = v.data2;
      end
      @(negedge OPB_CLK);
      if (BUSY) busy++;
      else done = 1'b1;
      if (TX_FIFO_WR) begin
        got = {got[151:0], TX_FIFO_DATA};
        nwr++;
        if (TX_FIFO_FULL) badwr++;
      end
      if (error_flag) begin
        errs++;
        if (first_err == 0) first_err = k;
      end
      @(posedge OPB_CLK);
      #1;
      RSP_REQ = 1'b0;
      k++;
    end
    TX_FIFO_FULL = 1'b0;
    chk($sformatf("v%0d bytes", vi), got, v.exp_bytes);
    chk($sformatf("v%0d nwr", vi), 160'(nwr), 160'(v.exp_nwr));
    chk($sformatf("v%0d busy_cycles", vi), 160'(busy), 160'(v.exp_busy));
    chk($sformatf("v%0d err_count", vi), 160'(errs), 160'((v.exp_err_k != 0) ? 1 : 0));
    chk($sformatf("v%0d err_cycle", vi), 160'(first_err), 160'(v.exp_err_k));
    chk($sformatf("v%0d wr_while_full", vi), 160'(badwr), 160'(0));
  endtask

  task automatic run_timeout();
    logic [159:0] got;
    int nwr, badwr, k, rises, extra_err, extra_wr;
    bit seen;
    got = '0; nwr = 0; badwr = 0; rises = -1; extra_err = 0; extra_wr = 0; seen = 1'b0;
    @(negedge OPB_CLK);
    rise_cnt = 0;
    RSP_REQ = 1'b1; RSP_ADDR = 32'h1234_5678; RSP_DATA = 32'hAABB_CCDD;
    @(posedge OPB_CLK);
    #1;
    RSP_REQ = 1'b0;
    k = 1;
    while (!seen && k < 3000) begin
      TX_FIFO_FULL = (k >= 6);
      @(negedge OPB_CLK);
      if (TX_FIFO_WR) begin
        got = {got[151:0], TX_FIFO_DATA};
        nwr++;
        if (TX_FIFO_FULL) badwr++;
      end
      if (error_flag) begin
        seen = 1'b1;
        rises = rise_cnt;
      end
      @(posedge OPB_CLK);
      #1;
      k++;
    end
    chk("to error_seen", 160'(seen), 160'(1));
    chk("to pulse_edges", 160'(rises), 160'(200));
    chk("to bytes", got, 160'h5C_12_34_56_78);
    chk("to nwr", 160'(nwr), 160'(5));
    chk("to wr_while_full", 160'(badwr), 160'(0));
    @(negedge OPB_CLK);
    chk("to busy_after", 160'({BUSY, error_flag}), 160'(0));
    TX_FIFO_FULL = 1'b0;
    repeat (20) begin
      @(negedge OPB_CLK);
      if (error_flag) extra_err++;
      if (TX_FIFO_WR || BUSY) extra_wr++;
    end
    chk("to extra_err", 160'(extra_err), 160'(0));
    chk("to no_resume", 160'(extra_wr), 160'(0));
  endtask

  initial begin
    int idle_bad;
    vecs[0] = '{addr: 32'h1234_5678, data: 32'hAABB_CCDD, full_mask: 32'h0, req2_k: 0,
                addr2: 32'h0, data2: 32'h0, exp_nwr: 10,
                exp_bytes: 160'h5C_12_34_56_78_AA_BB_CC_DD_A3, exp_busy: 10, exp_err_k: 0};
    vecs[1] = '{addr: 32'h1234_5678, data: 32'hAABB_CCDD, full_mask: 32'h0000_00F8, req2_k: 0,
                addr2: 32'h0, data2: 32'h0, exp_nwr: 10,
                exp_bytes: 160'h5C_12_34_56_78_AA_BB_CC_DD_A3, exp_busy: 15, exp_err_k: 0};
    vecs[2] = '{addr: 32'h0000_0000, data: 32'hFFFF_FFFF, full_mask: 32'h0, req2_k: 0,
                addr2: 32'h0, data2: 32'h0, exp_nwr: 10,
                exp_bytes: 160'h5C_00_00_00_00_FF_FF_FF_FF_A3, exp_busy: 10, exp_err_k: 0};
    vecs[3] = '{addr: 32'h0102_0304, data: 32'h0A0B_0C0D, full_mask: 32'h0000_0C00, req2_k: 0,
                addr2: 32'h0, data2: 32'h0, exp_nwr: 10,
                exp_bytes: 160'h5C_01_02_03_04_0A_0B_0C_0D_A3, exp_busy: 12, exp_err_k: 0};
    vecs[4] = '{addr: 32'h1234_5678, data: 32'hAABB_CCDD, full_mask: 32'h0, req2_k: 4,
                addr2: 32'hDEAD_BEEF, data2: 32'hDEAD_BEEF, exp_nwr: 10,
                exp_bytes: 160'h5C_12_34_56_78_AA_BB_CC_DD_A3, exp_busy: 10, exp_err_k: 5};
    vecs[5] = '{addr: 32'h1234_5678, data: 32'hAABB_CCDD, full_mask: 32'h0, req2_k: 10,
                addr2: 32'hCAFE_F00D, data2: 32'h8765_4321, exp_nwr: 20,
                exp_bytes: 160'h5C_12_34_56_78_AA_BB_CC_DD_A3_5C_CA_FE_F0_0D_87_65_43_21_A3,
                exp_busy: 20, exp_err_k: 0};

    OPB_RST = 1'b1; RSP_REQ = 1'b0; RSP_ADDR = '0; RSP_DATA = '0; TX_FIFO_FULL = 1'b0;
    #200;
    @(negedge OPB_CLK);
    chk("reset outputs", 160'({TX_FIFO_WR, TX_FIFO_DATA, BUSY, error_flag}), 160'(0));
    OPB_RST = 1'b0;
    idle_bad = 0;
    repeat (50) begin
      @(negedge OPB_CLK);
      if (TX_FIFO_WR || BUSY || error_flag) idle_bad++;
    end
    chk("idle quiet", 160'(idle_bad), 160'(0));

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], i);
      repeat (3) @(negedge OPB_CLK);
    end

    run_timeout();

    // Frame after an abort starts cleanly from the header.
    run_frame(vecs[2], 6);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
